// File: rtl/lock_sweep_pkg.sv
// Shared types and helpers for the ADPLL lock-range sweeper: FSM state encoding,
// default sizing constants and a width-parametrised saturating absolute value.
package lock_sweep_pkg;

   typedef enum logic [2:0] {
      IDLE,
      SETTLE,
      MEASURE,
      EVAL,
      DONE
   } state_e;

   localparam int unsigned DEF_K_WIDTH       = 16;
   localparam int unsigned DEF_ERR_WIDTH     = 8;
   localparam int unsigned DEF_SETTLE_CYCLES = 4096;
   localparam int unsigned DEF_WINDOW_CYCLES = 1024;
   localparam int unsigned DEF_LOCK_THRESH   = 4;
   localparam int unsigned DEF_CNT_WIDTH     = $clog2(DEF_SETTLE_CYCLES);

   // Bits needed to count 0..cycles-1; never narrower than one bit.
   function automatic int unsigned cnt_width(input int unsigned cycles);
      return (cycles <= 1) ? 1 : $clog2(cycles);
   endfunction

   // |value| clamped to the largest positive number of a signed 'width'-bit word,
   // so the most negative code maps to 2^(width-1)-1 instead of overflowing.
   function automatic logic [31:0] abs_sat(input logic signed [31:0] value,
                                           input int unsigned width);
      logic [31:0] mag;
      logic [31:0] lim;
      mag = (value < 0) ? 32'(-value) : 32'(value);
      lim = (32'd1 << (width - 1)) - 32'd1;
      return (mag > lim) ? lim : mag;
   endfunction

endpackage

// File: rtl/err_peak_tracker.sv
// Tracks the peak saturated |error| over a measurement window and flags whether
// any qualified sample was seen; clear_i restarts the window.
module err_peak_tracker
   import lock_sweep_pkg::*;
#(
   parameter int unsigned ERR_WIDTH = DEF_ERR_WIDTH
) (
   input  logic                        clk_i,
   input  logic                        rst_ni,
   input  logic                        clear_i,
   input  logic                        valid_i,
   input  logic signed [ERR_WIDTH-1:0] error_i,
   output logic        [ERR_WIDTH-2:0] peak_o,
   output logic                        seen_o
);

   logic [ERR_WIDTH-2:0] peak_q, peak_d, mag;
   logic                 seen_q, seen_d;

   assign mag = (ERR_WIDTH-1)'(abs_sat(32'(error_i), ERR_WIDTH));

   // NOTE: every variable gets a default at the top of always_comb so no path
   // leaves it unassigned, which would otherwise infer a latch.
   always_comb begin
      peak_d = peak_q;
      seen_d = seen_q;
      if (clear_i) begin
         peak_d = '0;
         seen_d = 1'b0;
      end else if (valid_i) begin
         seen_d = 1'b1;
         if (mag > peak_q) peak_d = mag;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples
   // pre-edge values regardless of statement order.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         peak_q <= '0;
         seen_q <= 1'b0;
      end else begin
         peak_q <= peak_d;
         seen_q <= seen_d;
      end
   end

   assign peak_o = peak_q;
   assign seen_o = seen_q;

endmodule

// File: rtl/lock_range_sweeper.sv
// ADPLL lock-range sweeper: steps k over [k_start..k_stop], settles, measures peak
// phase error per point and records the lowest/highest locked k. LRS_PEAK_OUT_EN adds peak_err_o.
module lock_range_sweeper
   import lock_sweep_pkg::*;
#(
   parameter int unsigned K_WIDTH       = DEF_K_WIDTH,
   parameter int unsigned ERR_WIDTH     = DEF_ERR_WIDTH,
   parameter int unsigned SETTLE_CYCLES = DEF_SETTLE_CYCLES,
   parameter int unsigned WINDOW_CYCLES = DEF_WINDOW_CYCLES,
   parameter int unsigned LOCK_THRESH   = DEF_LOCK_THRESH
) (
   input  logic                 fpga_clk_i,
   input  logic                 rst_pbn_i,
   input  logic                 start_i,
   input  logic [K_WIDTH-1:0]   k_start_i,
   input  logic [K_WIDTH-1:0]   k_stop_i,
   input  logic [K_WIDTH-1:0]   k_step_i,
   input  logic [ERR_WIDTH-1:0] error_i,
   input  logic                 error_valid_i,
   output logic [K_WIDTH-1:0]   k_val_o,
   output logic                 busy_o,
   output logic                 done_o,
   output logic                 range_valid_o,
   output logic [K_WIDTH-1:0]   lock_lo_o,
`ifdef LRS_PEAK_OUT_EN
   output logic [ERR_WIDTH-2:0] peak_err_o,
`endif
   output logic [K_WIDTH-1:0]   lock_hi_o
);

   localparam int unsigned CNT_W =
      cnt_width((SETTLE_CYCLES > WINDOW_CYCLES) ? SETTLE_CYCLES : WINDOW_CYCLES);
   localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] WINDOW_LAST = CNT_W'(WINDOW_CYCLES - 1);

   state_e               state_q;
   logic [K_WIDTH-1:0]   k_val_q, k_stop_q, k_step_q, lock_lo_q, lock_hi_q;
   logic [CNT_W-1:0]     cnt_q;
   logic                 busy_q, done_q, range_valid_q;
`ifdef LRS_PEAK_OUT_EN
   logic [ERR_WIDTH-2:0] peak_err_q;
`endif

   logic [ERR_WIDTH-2:0] peak;
   logic                 seen;
   logic                 locked;
   logic [K_WIDTH:0]     k_next;
   logic                 sweep_end;

   err_peak_tracker #(
      .ERR_WIDTH (ERR_WIDTH)
   ) u_peak (
      .clk_i   (fpga_clk_i),
      .rst_ni  (rst_pbn_i),
      .clear_i (state_q == SETTLE),
      .valid_i ((state_q == MEASURE) && error_valid_i),
      .error_i ($signed(error_i)),
      .peak_o  (peak),
      .seen_o  (seen)
   );

   // One bit wider than k so a wrap past the top of the k range ends the sweep.
   assign k_next    = {1'b0, k_val_q} + {1'b0, k_step_q};
   assign sweep_end = k_next[K_WIDTH] || (k_next[K_WIDTH-1:0] > k_stop_q);
   assign locked    = seen && (32'(peak) <= LOCK_THRESH);

   always_ff @(posedge fpga_clk_i or negedge rst_pbn_i) begin
      if (!rst_pbn_i) begin
         state_q       <= IDLE;
         k_val_q       <= '0;
         k_stop_q      <= '0;
         k_step_q      <= '0;
         lock_lo_q     <= '0;
         lock_hi_q     <= '0;
         cnt_q         <= '0;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
         range_valid_q <= 1'b0;
`ifdef LRS_PEAK_OUT_EN
         peak_err_q    <= '0;
`endif
      end else begin
         done_q <= 1'b0;
         unique case (state_q)
            IDLE: begin
               if (start_i) begin
                  k_val_q       <= k_start_i;
                  k_stop_q      <= k_stop_i;
                  k_step_q      <= (k_step_i == '0) ? K_WIDTH'(1) : k_step_i;
                  range_valid_q <= 1'b0;
                  busy_q        <= 1'b1;
                  cnt_q         <= '0;
                  state_q       <= (k_start_i > k_stop_i) ? DONE : SETTLE;
               end
            end
            SETTLE: begin
               if (cnt_q == SETTLE_LAST) begin
                  cnt_q   <= '0;
                  state_q <= MEASURE;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            MEASURE: begin
               if (cnt_q == WINDOW_LAST) begin
                  cnt_q   <= '0;
                  state_q <= EVAL;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            EVAL: begin
`ifdef LRS_PEAK_OUT_EN
               peak_err_q <= peak;
`endif
               // Only the outer edges of the locked region are kept; gaps are not.
               if (locked) begin
                  if (!range_valid_q) lock_lo_q <= k_val_q;
                  lock_hi_q     <= k_val_q;
                  range_valid_q <= 1'b1;
               end
               if (sweep_end) begin
                  state_q <= DONE;
               end else begin
                  k_val_q <= k_next[K_WIDTH-1:0];
                  state_q <= SETTLE;
               end
            end
            DONE: begin
               done_q  <= 1'b1;
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign k_val_o       = k_val_q;
   assign busy_o        = busy_q;
   assign done_o        = done_q;
   assign range_valid_o = range_valid_q;
   assign lock_lo_o     = lock_lo_q;
   assign lock_hi_o     = lock_hi_q;
`ifdef LRS_PEAK_OUT_EN
   assign peak_err_o    = peak_err_q;
`endif

endmodule

// File: tb/tb_lock_range_sweeper.sv
// Randomized self-checking bench for lock_range_sweeper; expected results come from
// a per-sweep model that walks k arithmetically over a table of error magnitudes.
module tb_lock_range_sweeper;

   localparam int KW = 16;
   localparam int EW = 8;
   localparam int S  = 8;
   localparam int W  = 16;
   localparam int TH = 4;
   localparam int PT = S + W + 1;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic [KW-1:0] ks = '0, ke = '0, kp = '0;
   logic [EW-1:0] err = '0;
   logic          ev = 1'b0;
   logic [KW-1:0] k_val, lo, hi;
   logic          busy, done, rvalid;
`ifdef LRS_PEAK_OUT_EN
   logic [EW-2:0] peak_err;
`endif

   lock_range_sweeper #(
      .K_WIDTH(KW), .ERR_WIDTH(EW), .SETTLE_CYCLES(S), .WINDOW_CYCLES(W), .LOCK_THRESH(TH)
   ) dut (
      .fpga_clk_i   (clk),
      .rst_pbn_i    (rst_n),
      .start_i      (start),
      .k_start_i    (ks),
      .k_stop_i     (ke),
      .k_step_i     (kp),
      .error_i      (err),
      .error_valid_i(ev),
      .k_val_o      (k_val),
      .busy_o       (busy),
      .done_o       (done),
      .range_valid_o(rvalid),
      .lock_lo_o    (lo),
`ifdef LRS_PEAK_OUT_EN
      .peak_err_o   (peak_err),
`endif
      .lock_hi_o    (hi)
   );

   always #5 clk = ~clk;

   int n_err = 0;
   int n_chk = 0;

   // Error magnitude the "ADPLL" shows at each k; absent entries mean zero error.
   int mag_tbl[int];
   bit valid_en = 1'b1;

   // Model state that survives between sweeps.
   int m_lo = 0, m_hi = 0, m_peak = 0;
   bit m_valid = 1'b0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic int mag_for(input int k);
      return mag_tbl.exists(k) ? mag_tbl[k] : 0;
   endfunction

   function automatic int sat(input int m);
      return (m > 127) ? 127 : m;
   endfunction

   // Error source: random strobes, each sample at full +/- magnitude or half of it.
   always @(negedge clk) begin
      int m;
      m  = mag_for(int'(k_val));
      ev = valid_en && ($urandom % 3 != 0);
      if (m >= 128)             err = 8'h80;
      else if ($urandom % 4 == 0) err = 8'(m / 2);
      else if ($urandom % 2 == 0) err = 8'(m);
      else                        err = 8'(-m);
   end

   task automatic do_sweep(input int s, input int e, input int p, input bit inject,
                           input string name);
      int st, n, lat, budget, last_k, m;
      st = (p == 0) ? 1 : p;
      n = 0;
      last_k = s;
      m_valid = 1'b0;
      for (longint k = s; k <= e; k += st) begin
         n++;
         last_k = int'(k);
         m = valid_en ? sat(mag_for(int'(k))) : 0;
         m_peak = m;
         if (valid_en && m <= TH) begin
            if (!m_valid) m_lo = int'(k);
            m_hi = int'(k);
            m_valid = 1'b1;
         end
      end
      ks = KW'(s); ke = KW'(e); kp = KW'(p);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      lat = 1;
      check({name, "_busy"}, 32'(busy), 32'd1);
      budget = n * PT + 20;
      while (!done && lat < budget) begin
         if (inject && lat == 5 && n * PT + 2 > 8) begin
            start = 1'b1;
            ks = KW'($urandom); ke = KW'($urandom); kp = KW'($urandom);
         end
         @(negedge clk);
         start = 1'b0;
         lat++;
      end
      check({name, "_latency"}, 32'(lat), 32'(n * PT + 2));
      check({name, "_done"}, 32'(done), 32'd1);
      check({name, "_busy_end"}, 32'(busy), 32'd0);
      check({name, "_valid"}, 32'(rvalid), 32'(m_valid));
      check({name, "_lo"}, 32'(lo), 32'(m_lo));
      check({name, "_hi"}, 32'(hi), 32'(m_hi));
      check({name, "_kval"}, 32'(k_val), 32'(last_k));
`ifdef LRS_PEAK_OUT_EN
      check({name, "_peak"}, 32'(peak_err), 32'(m_peak));
`endif
      @(negedge clk);
      check({name, "_done_pulse"}, 32'(done), 32'd0);
   endtask

   task automatic apply_reset();
      rst_n = 1'b0;
      m_lo = 0; m_hi = 0; m_peak = 0; m_valid = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   initial begin
      int s, e, p, extra_done;
      #12;
      check("rst_kval", 32'(k_val), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_valid", 32'(rvalid), 32'd0);
      check("rst_lohi", {lo, hi}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      mag_tbl.delete();
      do_sweep(10, 20, 5, 1'b0, "zero_err");

      mag_tbl.delete();
      mag_tbl[10] = 2; mag_tbl[15] = 9; mag_tbl[20] = 4;
      do_sweep(10, 20, 5, 1'b1, "mixed_err");

      mag_tbl.delete();
      mag_tbl[30] = 9; mag_tbl[31] = 0; mag_tbl[32] = 7; mag_tbl[33] = 3; mag_tbl[34] = 5;
      do_sweep(30, 34, 0, 1'b1, "gap_step0");

      apply_reset();
      mag_tbl.delete();
      mag_tbl[10] = 128; mag_tbl[15] = 128; mag_tbl[20] = 128;
      do_sweep(10, 20, 5, 1'b0, "neg_sat");

      mag_tbl.delete();
      do_sweep(16'hFFF0, 16'hFFFF, 16'h0020, 1'b0, "carry");

      valid_en = 1'b0;
      do_sweep(40, 60, 7, 1'b1, "no_valid");
      valid_en = 1'b1;
      do_sweep(50, 20, 3, 1'b0, "start_gt_stop");

      for (int r = 0; r < 6; r++) begin
         s = $urandom_range(0, 300);
         e = s + $urandom_range(0, 40);
         p = $urandom_range(0, 12);
         mag_tbl.delete();
         for (int k = s; k <= e; k++)
            mag_tbl[k] = ($urandom % 6 == 0) ? 128 : $urandom_range(0, 8);
         do_sweep(s, e, p, 1'b1, $sformatf("rand%0d", r));
      end

      // Reset in the middle of the first measurement window.
      ks = 16'd100; ke = 16'd140; kp = 16'd10;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (S + 4) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("midrst_kval", 32'(k_val), 32'd0);
      check("midrst_busy", 32'(busy), 32'd0);
      check("midrst_valid_lohi", {15'd0, rvalid, lo | hi}, 32'd0);
`ifdef LRS_PEAK_OUT_EN
      check("midrst_peak", 32'(peak_err), 32'd0);
`endif
      @(negedge clk);
      rst_n = 1'b1;
      extra_done = 0;
      repeat (6 * PT) begin
         @(negedge clk);
         if (done) extra_done++;
      end
      check("midrst_no_done", 32'(extra_done), 32'd0);
      check("midrst_idle", 32'(busy), 32'd0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
